fifo_ctrl: RTL
==============

# fifo_ctrl

Control stage of the 8-deep FIFO, sitting directly upstream of `fifo_cal` and the register file. Samples the write/read requests each cycle, runs the FIFO state machine, holds the head/tail pointers and occupancy count, and drives the write/read strobes to the storage array. Also presents the handshake and status flags (`full`, `empty`, acknowledge and error) to the FIFO's client.

## Interface
- No parameters; depth fixed at 8 entries (3-bit pointers, 4-bit count).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write request, sampled at each rising edge.
- `rd_en`  in  1  read request, sampled at each rising edge.
- `state`  out  3  registered FSM state.
- `head`  out  3  read pointer: address of the oldest entry.
- `tail`  out  3  write pointer: address of the next free slot.
- `data_count`  out  4  occupancy, 0..8.
- `we`  out  1  storage write strobe; write address = `tail`.
- `re`  out  1  storage read strobe; read address = `head`.
- `full` / `empty`  out  1  `data_count==8` / `data_count==0`.
- `wr_ack` / `wr_err`  out  1  accepted write / rejected write.
- `rd_ack` / `rd_err`  out  1  accepted read / rejected read.

## Operation
- State encodings: IDLE=3'b000, WRITE=3'b001, READ=3'b010, WR_ERR=3'b101, RD_ERR=3'b110.
- The next state is decided from `wr_en`, `rd_en` and `nc`.
  - `nc` = the occupancy that becomes valid at the same edge, i.e. `data_count` updated for the current state.
- Transitions:
  - `wr_en & ~rd_en`: WR_ERR if `nc==8`, else WRITE.
  - `rd_en & ~wr_en`: RD_ERR if `nc==0`, else READ.
  - Both or neither asserted: IDLE (no operation, no error).
- In WRITE:
  - `we=1`, `wr_ack=1`.
  - At the next edge: `tail<=tail+1` (mod 8) and `data_count<=data_count+1`.
- In READ:
  - `re=1`, `rd_ack=1`.
  - At the next edge: `head<=head+1` (mod 8) and `data_count<=data_count-1`.
- In WR_ERR: `wr_err=1`. In RD_ERR: `rd_err=1`. Pointers and count hold in both error states and in IDLE.
- Pointer arithmetic is 3-bit and wraps 7→0. Count arithmetic is 4-bit; it never exceeds 8 and never goes below 0, guaranteed by the error states.
- Strobes and ack/err are decoded from the registered `state`, so exactly one of `we`, `re`, `wr_err`, `rd_err` or none is high in any cycle.
- `full` and `empty` are decoded from the registered `data_count`.

## Timing
- Request at edge k → `state` valid after edge k → strobe and ack/err high during cycle k+1 → pointer/count update at edge k+1.
- Back-to-back requests sustain one operation per cycle with no bubble.
- The 8th consecutive write is acknowledged. The 9th request in that run yields WR_ERR, with no write strobe.
- Reset values: `state`=IDLE, `head`=`tail`=0, `data_count`=0.
  - All strobes and ack/err flags are 0.
  - `empty`=1, `full`=0.
- Reset mid-operation dominates all requests. The pending update is discarded; the cycle after the reset edge shows reset values.
- Requests are ignored during any cycle in which `reset` is sampled high.

## Configuration
- `FIFO_CTRL_ALMOST_EN` defined: adds outputs `almost_full` (`data_count>=7`) and `almost_empty` (`data_count<=1`).
  - Both are combinational from the registered count.
  - Reset values: `almost_full`=0, `almost_empty`=1.
- Not defined: these ports and their logic do not exist. All other behaviour is identical.

## Structure
- Shared package `fifo_pkg`:
  - State encodings.
  - `FIFO_DEPTH`=8, `PTR_W`=3, `CNT_W`=4.
  - Used by `fifo_cal` and the register file as well.
- One sub-module, `fifo_ns`: the combinational next-state function (`wr_en`, `rd_en`, `nc` → next state).
- The top level holds the state, pointer and count registers, plus the output decode.

## Test plan
- Reset, then idle 3 cycles → `state`=IDLE, `head`=`tail`=0, `data_count`=0, `empty`=1, all strobes 0.
- 8 back-to-back writes → `wr_ack` high 8 cycles, `tail` ends 0 (wrapped), `data_count`=8, `full`=1. A 9th write → `wr_err`=1, `we`=0, count stays 8.
- From full, 8 back-to-back reads → `head` wraps to 0, `data_count`=0, `empty`=1. A further read → `rd_err`=1, `re`=0.
- `wr_en` and `rd_en` both high at `data_count`=3 → `state`=IDLE, no strobe, count stays 3.
- Alternating write/read 20 cycles starting empty → count toggles 1/0, `head`/`tail` wrap past 7, no error flag ever set.
- Assert `reset` during a write burst at `data_count`=5 → next cycle shows all reset values; a subsequent single write lands at `tail`=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-deep FIFO: depth, pointer/count widths and FSM encodings.
package fifo_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int PTR_W      = 3;
  localparam int CNT_W      = 4;

  localparam logic [CNT_W-1:0] CNT_FULL  = 4'd8;
  localparam logic [CNT_W-1:0] CNT_EMPTY = 4'd0;

  localparam logic [2:0] ST_IDLE   = 3'b000;
  localparam logic [2:0] ST_WRITE  = 3'b001;
  localparam logic [2:0] ST_READ   = 3'b010;
  localparam logic [2:0] ST_WR_ERR = 3'b101;
  localparam logic [2:0] ST_RD_ERR = 3'b110;

endpackage

// File: rtl/fifo_ns.sv
// Combinational next-state function of the FIFO control FSM.
module fifo_ns
  import fifo_pkg::*;
(
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [CNT_W-1:0] nc,
  output logic [2:0]       ns
);

  // Simultaneous or absent requests fall through to IDLE.
  always_comb begin
    ns = ST_IDLE;
    if (wr_en && !rd_en) begin
      ns = (nc == CNT_FULL) ? ST_WR_ERR : ST_WRITE;
    end else if (rd_en && !wr_en) begin
      ns = (nc == CNT_EMPTY) ? ST_RD_ERR : ST_READ;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control stage: FSM, head/tail pointers, occupancy count and strobe/flag decode.
// Optional FIFO_CTRL_ALMOST_EN adds almost_full/almost_empty outputs.
module fifo_ctrl
  import fifo_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [2:0]       state,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [CNT_W-1:0] data_count,
  output logic             we,
  output logic             re,
  output logic             full,
  output logic             empty,
  output logic             wr_ack,
  output logic             wr_err,
  output logic             rd_ack,
  output logic             rd_err
`ifdef FIFO_CTRL_ALMOST_EN
  ,
  output logic             almost_full,
  output logic             almost_empty
`endif
);

  logic [2:0]       state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // The operation held in state_q commits at the coming edge; count_d is that
  // committed occupancy and doubles as nc for the next-state decision.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (state_q == ST_WRITE) begin
      tail_d  = tail_q + 3'd1;
      count_d = count_q + 4'd1;
    end else if (state_q == ST_READ) begin
      head_d  = head_q + 3'd1;
      count_d = count_q - 4'd1;
    end
  end

  fifo_ns u_ns (
    .wr_en (wr_en),
    .rd_en (rd_en),
    .nc    (count_d),
    .ns    (state_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign state      = state_q;
  assign head       = head_q;
  assign tail       = tail_q;
  assign data_count = count_q;

  assign we     = (state_q == ST_WRITE);
  assign wr_ack = (state_q == ST_WRITE);
  assign re     = (state_q == ST_READ);
  assign rd_ack = (state_q == ST_READ);
  assign wr_err = (state_q == ST_WR_ERR);
  assign rd_err = (state_q == ST_RD_ERR);

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == CNT_EMPTY);

`ifdef FIFO_CTRL_ALMOST_EN
  assign almost_full  = (count_q >= 4'd7);
  assign almost_empty = (count_q <= 4'd1);
`endif

endmodule
